tagram_ctrl: RTL and testbench
==============================

Name: tagram_ctrl

Overview:
- Sequencer and arbiter in front of one 256x21 single-port tag/valid RAM (8-bit address, 3 byte-enable lanes) in the cache subsystem.
- Shares the RAM between the pipeline lookup port (read) and the refill/maintenance port (write).
- Runs a clear sweep over all entries after reset and on request.
- Hides the RAM's 1-cycle read latency behind a valid/ready handshake.

Parameters:
- DEPTH, 256, number of entries; ADDR_W = log2(DEPTH).
- DATA_W, 21, entry width; lanes are [7:0], [15:8], [20:16].
- WR_BURST_MAX, 4, maximum consecutive write grants while a read waits.
- CLR_VALUE, 21'h0, word written to every entry by a clear sweep.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- rd_req  in  1  lookup request.
- rd_addr  in  8  lookup index.
- rd_ready  out  1  lookup accepted this cycle.
- rd_rvalid  out  1  lookup data valid.
- rd_rdata  out  21  lookup data.
- wr_req  in  1  write request.
- wr_addr  in  8  write index.
- wr_data  in  21  write data.
- wr_ben  in  3  lane enables.
- wr_ready  out  1  write accepted this cycle.
- clr_req  in  1  pulse: start a clear sweep.
- busy  out  1  clear sweep in progress.
- ram_ce  out  1  RAM clock enable.
- ram_oce  out  1  RAM output enable; constant 1.
- ram_wre  out  1  RAM write enable.
- ram_ad  out  8  RAM address.
- ram_din  out  21  RAM write data.
- ram_ben  out  3  RAM lane enables.
- ram_dout  in  21  RAM read data, valid 1 cycle after a read access.

Behaviour:
- Clock and reset: single clock clk. Reset resetn is asynchronous, active-low.
- Reset values:
  - All outputs 0, except ram_oce = 1 and busy = 1.
  - State = CLEAR, clear counter = 0.
  - Burst counter = 0.
- State CLEAR, one RAM access per cycle:
  - Drives ram_ce = 1, ram_wre = 1, ram_ad = counter, ram_din = CLR_VALUE, ram_ben = 3'b111.
  - Counter increments by 1 each cycle.
  - After address DEPTH-1 is written, the next cycle enters RUN with busy = 0.
  - Sweep takes exactly DEPTH cycles.
  - rd_ready = wr_ready = 0 throughout.
- State RUN, one grant per cycle at most:
  - Only wr_req: grant write.
  - Only rd_req: grant read.
  - Both: write wins unless the burst counter equals WR_BURST_MAX, then read wins.
  - Burst counter: increments on a write grant while rd_req = 1; clears on any read grant or when rd_req = 0.
- Grant signalling:
  - The grant is returned combinationally: rd_ready or wr_ready is high in the same cycle the RAM is driven.
  - Write grant: ram_ce = 1, ram_wre = 1, ram_ad = wr_addr, ram_din = wr_data, ram_ben = wr_ben.
  - Read grant: ram_ce = 1, ram_wre = 0, ram_ben = 3'b111.
  - No grant: ram_ce = 0.
- Read data:
  - rd_rvalid is registered and asserts exactly 1 cycle after a read grant, with rd_rdata = ram_dout.
  - Back-to-back read grants give back-to-back rd_rvalid.
  - rd_rdata holds its value while rd_rvalid = 0.
- Write then read of the same address on consecutive cycles returns the new data (RAM ordering; no bypass needed).
- wr_ben = 0 on a granted write is legal: the access is consumed and nothing changes.
- clr_req:
  - In RUN: sampled, and the state enters CLEAR on the next cycle, counter = 0, busy = 1.
  - A read granted in the same cycle as clr_req still returns rd_rvalid in the first CLEAR cycle.
  - A write request in that same cycle is not granted; the requester keeps it pending.
  - clr_req during CLEAR is ignored; the sweep does not restart.
- Reset mid-sweep or mid-read drops any pending rd_rvalid and restarts CLEAR from address 0.
- Requesters must hold req, addr and data stable until ready.

Decomposition:
- Shared package tagram_pkg holds:
  - constants TAG_DEPTH = 256, TAG_ADDR_W = 8, TAG_DATA_W = 21, TAG_BEN_W = 3;
  - lane boundary constants;
  - state enum {CLEAR, RUN}.
- One natural sub-module, tagram_arb: the 2-requester write-priority arbiter with burst-limit counter, outputs grant_rd and grant_wr.
- The top level holds the state machine, clear counter, RAM muxing and read-return register.

Test Plan:
- Release resetn at cycle 0 → busy = 1 for exactly 256 cycles; ram_ad steps 0..255 with ram_wre = 1, ram_din = 0; then busy = 0 and reads of 0x00 and 0xFF return 0.
- Write addr 0x12, data 0x1ABCDE, ben 3'b111; next cycle read 0x12 → rd_rvalid one cycle after rd_ready, rd_rdata = 0x1ABCDE.
- Write addr 0x12, data 0x000055, ben 3'b001 over the prior value → read returns 0x1ABC55.
- Hold rd_req and wr_req high for 12 cycles (WR_BURST_MAX = 4) → grant pattern W,W,W,W,R repeating; a read is never starved longer than 4 cycles.
- Issue clr_req in the same cycle as a read grant of addr 0x12 → rd_rvalid appears once (0x1ABC55), then a 256-cycle sweep, then read 0x12 = 0.
- Assert resetn = 0 at sweep address 100 → outputs reset immediately; after release the sweep restarts at address 0.

Source files
------------

// File: rtl/tagram_pkg.sv
// Shared constants and types for the tag/valid RAM controller.
package tagram_pkg;

  localparam int unsigned TAG_DEPTH  = 256;
  localparam int unsigned TAG_ADDR_W = 8;
  localparam int unsigned TAG_DATA_W = 21;
  localparam int unsigned TAG_BEN_W  = 3;

  localparam int unsigned TAG_LANE0_LSB = 0;
  localparam int unsigned TAG_LANE0_MSB = 7;
  localparam int unsigned TAG_LANE1_LSB = 8;
  localparam int unsigned TAG_LANE1_MSB = 15;
  localparam int unsigned TAG_LANE2_LSB = 16;
  localparam int unsigned TAG_LANE2_MSB = 20;

  localparam int unsigned TAG_WR_BURST_MAX = 4;

  localparam logic [TAG_DATA_W-1:0] TAG_CLR_VALUE = '0;
  localparam logic [TAG_BEN_W-1:0]  TAG_BEN_ALL   = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } tag_state_e;

endpackage

// File: rtl/tagram_arb.sv
// Write-priority arbiter for the shared tag RAM; a waiting read is forced
// through after BURST_MAX consecutive write grants.
module tagram_arb
  import tagram_pkg::*;
#(
  parameter int unsigned BURST_MAX = TAG_WR_BURST_MAX
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic rd_req,
  input  logic wr_req,
  output logic grant_rd,
  output logic grant_wr
);

  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

  logic [CNT_W-1:0] r_burst;
  logic             w_at_max;

  assign w_at_max = (r_burst == CNT_W'(BURST_MAX));
  assign grant_wr = en & wr_req & (~rd_req | ~w_at_max);
  assign grant_rd = en & rd_req & ~grant_wr;

  // Counts writes that overtook a waiting read; any other cycle restarts it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_burst <= '0;
    end else if (grant_wr && rd_req) begin
      r_burst <= r_burst + CNT_W'(1);
    end else begin
      r_burst <= '0;
    end
  end

endmodule

// File: rtl/tagram_ctrl.sv
// Sequencer/arbiter in front of the 256x21 single-port tag RAM: clear sweep,
// lookup/refill arbitration and read-return handshake.
module tagram_ctrl
  import tagram_pkg::*;
#(
  parameter int unsigned            WR_BURST_MAX = TAG_WR_BURST_MAX,
  parameter logic [TAG_DATA_W-1:0]  CLR_VALUE    = TAG_CLR_VALUE
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rd_req,
  input  logic [TAG_ADDR_W-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_rvalid,
  output logic [TAG_DATA_W-1:0] rd_rdata,
  input  logic                  wr_req,
  input  logic [TAG_ADDR_W-1:0] wr_addr,
  input  logic [TAG_DATA_W-1:0] wr_data,
  input  logic [TAG_BEN_W-1:0]  wr_ben,
  output logic                  wr_ready,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  ram_ce,
  output logic                  ram_oce,
  output logic                  ram_wre,
  output logic [TAG_ADDR_W-1:0] ram_ad,
  output logic [TAG_DATA_W-1:0] ram_din,
  output logic [TAG_BEN_W-1:0]  ram_ben,
  input  logic [TAG_DATA_W-1:0] ram_dout
);

  tag_state_e            r_state;
  tag_state_e            w_state_nxt;
  logic [TAG_ADDR_W-1:0] r_clr_cnt;
  logic                  r_rvalid;
  logic [TAG_DATA_W-1:0] r_rdata_hold;
  logic                  w_run;
  logic                  w_grant_rd;
  logic                  w_grant_wr;

  assign w_run = (r_state == RUN);

  // A pending write is held off in the cycle a clear is requested.
  tagram_arb #(
    .BURST_MAX (WR_BURST_MAX)
  ) u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .en       (w_run),
    .rd_req   (rd_req),
    .wr_req   (wr_req & ~clr_req),
    .grant_rd (w_grant_rd),
    .grant_wr (w_grant_wr)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (r_clr_cnt == TAG_ADDR_W'(TAG_DEPTH - 1)) w_state_nxt = RUN;
      RUN:     if (clr_req) w_state_nxt = CLEAR;
      default: w_state_nxt = CLEAR;
    endcase
  end

  // Sweep address; parked at zero outside CLEAR so every sweep starts at 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clr_cnt <= '0;
    end else if (w_run) begin
      r_clr_cnt <= '0;
    end else begin
      r_clr_cnt <= r_clr_cnt + TAG_ADDR_W'(1);
    end
  end

  always_comb begin
    rd_ready = 1'b0;
    wr_ready = 1'b0;
    ram_ce   = 1'b0;
    ram_wre  = 1'b0;
    ram_ad   = '0;
    ram_din  = '0;
    ram_ben  = '0;
    case (r_state)
      CLEAR: begin
        // Sweep drive is suppressed while reset is held.
        if (resetn) begin
          ram_ce  = 1'b1;
          ram_wre = 1'b1;
          ram_ad  = r_clr_cnt;
          ram_din = CLR_VALUE;
          ram_ben = TAG_BEN_ALL;
        end
      end
      RUN: begin
        if (w_grant_wr) begin
          wr_ready = 1'b1;
          ram_ce   = 1'b1;
          ram_wre  = 1'b1;
          ram_ad   = wr_addr;
          ram_din  = wr_data;
          ram_ben  = wr_ben;
        end else if (w_grant_rd) begin
          rd_ready = 1'b1;
          ram_ce   = 1'b1;
          ram_ad   = rd_addr;
          ram_ben  = TAG_BEN_ALL;
        end
      end
      default: ;
    endcase
  end

  // RAM data is presented directly in the valid cycle and held afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rvalid     <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      r_rvalid <= w_grant_rd;
      if (r_rvalid) r_rdata_hold <= ram_dout;
    end
  end

  assign rd_rvalid = r_rvalid;
  assign rd_rdata  = r_rvalid ? ram_dout : r_rdata_hold;
  assign busy      = ~w_run;
  assign ram_oce   = 1'b1;

endmodule

// File: tb/tb_tagram_ctrl.sv
// Bench for tagram_ctrl: RAM model, behavioural reference checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tagram_ctrl;
  import tagram_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rd_req, rd_ready, rd_rvalid;
  logic [7:0]  rd_addr;
  logic [20:0] rd_rdata;
  logic        wr_req, wr_ready;
  logic [7:0]  wr_addr;
  logic [20:0] wr_data;
  logic [2:0]  wr_ben;
  logic        clr_req, busy;
  logic        ram_ce, ram_oce, ram_wre;
  logic [7:0]  ram_ad;
  logic [20:0] ram_din, ram_dout;
  logic [2:0]  ram_ben;

  int checks = 0;
  int errors = 0;

  tagram_ctrl dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ben(wr_ben),
    .wr_ready(wr_ready), .clr_req(clr_req), .busy(busy),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_ben(ram_ben), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] merge(input logic [20:0] o, input logic [20:0] n,
                                        input logic [2:0] b);
    logic [20:0] r;
    r = o;
    if (b[0]) r[TAG_LANE0_MSB:TAG_LANE0_LSB] = n[TAG_LANE0_MSB:TAG_LANE0_LSB];
    if (b[1]) r[TAG_LANE1_MSB:TAG_LANE1_LSB] = n[TAG_LANE1_MSB:TAG_LANE1_LSB];
    if (b[2]) r[TAG_LANE2_MSB:TAG_LANE2_LSB] = n[TAG_LANE2_MSB:TAG_LANE2_LSB];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single-port RAM with a registered read port (1-cycle latency).
  logic [20:0] mem [TAG_DEPTH];
  logic [20:0] ram_q = '0;
  assign ram_dout = ram_q;
  initial for (int i = 0; i < TAG_DEPTH; i++) mem[i] = 21'($urandom);
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) mem[ram_ad] <= merge(mem[ram_ad], ram_din, ram_ben);
      else         ram_q <= mem[ram_ad];
    end
  end

  // Reference model state
  int          m_sweep = TAG_DEPTH;
  int          m_burst = 0;
  bit          m_rv = 1'b0;
  logic [20:0] m_rv_data = '0;
  logic [20:0] m_hold = '0;
  logic [20:0] m_mem [TAG_DEPTH];
  initial for (int i = 0; i < TAG_DEPTH; i++) m_mem[i] = '0;

  always @(negedge clk) begin : mon
    bit eg_w, eg_r;
    eg_w = 1'b0;
    eg_r = 1'b0;
    if (!resetn) begin
      chk("rst_rd_ready", 32'(rd_ready), 0);
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_rvalid", 32'(rd_rvalid), 0);
      chk("rst_rdata", 32'(rd_rdata), 0);
      chk("rst_ce", 32'(ram_ce), 0);
      chk("rst_wre", 32'(ram_wre), 0);
      chk("rst_ad", 32'(ram_ad), 0);
      chk("rst_din", 32'(ram_din), 0);
      chk("rst_ben", 32'(ram_ben), 0);
      chk("rst_oce", 32'(ram_oce), 1);
      chk("rst_busy", 32'(busy), 1);
      m_sweep = TAG_DEPTH;
      m_burst = 0;
      m_rv = 1'b0;
      m_hold = '0;
    end else begin
      if (m_sweep == 0) begin
        if (wr_req && !clr_req && (!rd_req || m_burst < TAG_WR_BURST_MAX)) eg_w = 1'b1;
        else if (rd_req) eg_r = 1'b1;
      end
      chk("busy", 32'(busy), 32'(m_sweep > 0));
      chk("wr_ready", 32'(wr_ready), 32'(eg_w));
      chk("rd_ready", 32'(rd_ready), 32'(eg_r));
      chk("ram_ce", 32'(ram_ce), 32'((m_sweep > 0) || eg_w || eg_r));
      chk("ram_wre", 32'(ram_wre), 32'((m_sweep > 0) || eg_w));
      chk("ram_oce", 32'(ram_oce), 1);
      chk("rd_rvalid", 32'(rd_rvalid), 32'(m_rv));
      chk("rd_rdata", 32'(rd_rdata), 32'(m_rv ? m_rv_data : m_hold));
      if (m_sweep > 0) begin
        chk("sweep_ad", 32'(ram_ad), 32'(TAG_DEPTH - m_sweep));
        chk("sweep_din", 32'(ram_din), 32'(TAG_CLR_VALUE));
        chk("sweep_ben", 32'(ram_ben), 7);
      end else if (eg_w) begin
        chk("wr_ad", 32'(ram_ad), 32'(wr_addr));
        chk("wr_din", 32'(ram_din), 32'(wr_data));
        chk("wr_ben", 32'(ram_ben), 32'(wr_ben));
      end else if (eg_r) begin
        chk("rd_ad", 32'(ram_ad), 32'(rd_addr));
        chk("rd_ben", 32'(ram_ben), 7);
      end
      // Advance the model across the coming rising edge.
      if (m_rv) m_hold = m_rv_data;
      m_rv = eg_r;
      if (eg_r) m_rv_data = m_mem[rd_addr];
      if (m_sweep > 0) begin
        m_mem[TAG_DEPTH - m_sweep] = TAG_CLR_VALUE;
        m_sweep--;
        m_burst = 0;
      end else begin
        if (eg_w) m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_ben);
        m_burst = (eg_w && rd_req) ? m_burst + 1 : 0;
        if (clr_req) m_sweep = TAG_DEPTH;
      end
    end
  end

  task automatic count_busy(input int start, output int n);
    n = start;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [20:0] d, input logic [2:0] b);
    int n;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_ben = b;
    n = 0;
    do begin @(negedge clk); n++; end while (!wr_ready && n < 600);
    if (!wr_ready) chk("wr_grant_timeout", 0, 1);
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [20:0] d);
    int n;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_ready && n < 600);
    if (!rd_ready) chk("rd_grant_timeout", 0, 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid_latency", 32'(rd_rvalid), 1);
    d = rd_rdata;
  endtask

  initial begin : drv
    logic [20:0] d;
    logic [11:0] pat;
    int n;
    bit g_r, g_w;
    resetn = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0;
    wr_addr = '0; wr_data = '0; wr_ben = '0; clr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    count_busy(0, n);
    chk("first_sweep_len", 32'(n), 256);

    do_read(8'h00, d); chk("rd_00_after_clear", 32'(d), 0);
    do_read(8'hFF, d); chk("rd_ff_after_clear", 32'(d), 0);

    do_write(8'h12, 21'h1ABCDE, 3'b111);
    do_read(8'h12, d); chk("rd_12_full", 32'(d), 32'h1ABCDE);
    do_write(8'h12, 21'h000055, 3'b001);
    do_read(8'h12, d); chk("rd_12_lane0", 32'(d), 32'h1ABC55);
    do_write(8'h12, 21'h1FFFFF, 3'b000);
    do_read(8'h12, d); chk("rd_12_ben0", 32'(d), 32'h1ABC55);

    // Contention: both requesters held for 12 cycles.
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 8'h30; wr_req = 1'b1; wr_addr = 8'h40;
    wr_data = 21'h0A5A5A; wr_ben = 3'b111;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pat[11-i] = wr_ready;
      @(posedge clk); #1;
    end
    rd_req = 1'b0; wr_req = 1'b0;
    chk("burst_pattern", 32'(pat), 32'b1111_0111_1011);

    // Clear requested in the same cycle as a read grant.
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 8'h12; clr_req = 1'b1;
    @(negedge clk);
    chk("clr_cycle_rd_ready", 32'(rd_ready), 1);
    @(posedge clk); #1;
    rd_req = 1'b0; clr_req = 1'b0;
    @(negedge clk);
    chk("clr_rvalid", 32'(rd_rvalid), 1);
    chk("clr_rdata", 32'(rd_rdata), 32'h1ABC55);
    chk("clr_busy", 32'(busy), 1);
    count_busy(1, n);
    chk("clr_sweep_len", 32'(n), 256);
    do_read(8'h12, d); chk("rd_12_after_clr", 32'(d), 0);

    // Reset in the middle of a sweep.
    @(posedge clk); #1 clr_req = 1'b1;
    @(posedge clk); #1 clr_req = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (busy && ram_ad == 8'd100) break;
      @(posedge clk); #1;
    end
    chk("reached_ad_100", 32'(ram_ad), 100);
    resetn = 1'b0;
    #1;
    chk("midsweep_rst_ce", 32'(ram_ce), 0);
    chk("midsweep_rst_busy", 32'(busy), 1);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("restart_ad", 32'(ram_ad), 0);
    count_busy(1, n);
    chk("restart_sweep_len", 32'(n), 256);

    // Randomized traffic; requests held until granted.
    g_r = 1'b1; g_w = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      clr_req = 1'b0;
      if (!rd_req || g_r) begin
        rd_req  = ($urandom_range(0, 99) < 55);
        rd_addr = 8'($urandom_range(0, 31));
      end
      if (!wr_req || g_w) begin
        wr_req  = ($urandom_range(0, 99) < 55);
        wr_addr = 8'($urandom_range(0, 31));
        wr_data = 21'($urandom);
        wr_ben  = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 399) == 0) clr_req = 1'b1;
      @(negedge clk);
      g_r = rd_ready;
      g_w = wr_ready;
    end
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0; clr_req = 1'b0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
